// File: rtl/nn_pkg.sv
// Shared types and constants for the NN activation datapath.
// Word/address widths, the bank depth and the stream FSM encoding.
// Imported by the activation buffer, its interface and its RAM banks.
package nn_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  // One bit wider than an address so a full bank (DEPTH) is representable.
  typedef logic [ADDR_W:0]   cnt_t;

  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t STREAM = 2'd1;
  localparam state_t DRAIN  = 2'd2;

endpackage

// File: rtl/layer_activation_buffer_if.sv
// Bundle of load/activation/stream signals around the activation buffer.
// master: controller/AF/MAC side that drives strobes and consumes the stream.
// slave: the activation buffer itself.
interface layer_activation_buffer_if;
  import nn_pkg::*;

  logic  ld_valid;
  data_t ld_data;
  logic  ld_clr;
  logic  act_valid;
  data_t act_data;
  logic  layer_swap;
  logic  rd_start;
  addr_t rd_len;
  logic  rd_valid;
  data_t rd_data;
  logic  rd_last;
  logic  busy;
  cnt_t  wr_count;
  logic  err;

  modport master (
    output ld_valid, ld_data, ld_clr, act_valid, act_data, layer_swap, rd_start, rd_len,
    input  rd_valid, rd_data, rd_last, busy, wr_count, err
  );

  modport slave (
    input  ld_valid, ld_data, ld_clr, act_valid, act_data, layer_swap, rd_start, rd_len,
    output rd_valid, rd_data, rd_last, busy, wr_count, err
  );

endinterface

// File: rtl/layer_activation_buffer_act_bank_ram.sv
// One activation bank: simple dual-port RAM, one write port, one synchronous read port.
// Latency: rdata valid the cycle after re is sampled.
// Backpressure: none; writes and reads are accepted every cycle.
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata registered read data.
module act_bank_ram
  import nn_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  addr_t waddr,
  input  data_t wdata,
  input  logic  re,
  input  addr_t raddr,
  output data_t rdata
);

  data_t mem [DEPTH];

  // Contents and read register are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/layer_activation_buffer.sv
// Ping-pong activation store: AF results fill the WRITE bank, the READ bank streams to the MAC.
// Latency: first rd_valid two cycles after rd_start is present; one word per cycle after that.
// Backpressure: none; illegal loads/swaps/overflows are dropped and raise the sticky err.
// Ports: clk, rst_n (async, active-low); bus (slave modport) carries load, activation,
// swap, stream request/response, busy, wr_count and err.
module layer_activation_buffer
  import nn_pkg::*;
(
  input logic                      clk,
  input logic                      rst_n,
  layer_activation_buffer_if.slave bus
);

  state_t state, state_nxt;
  logic   bank_sel;            // 0: bank0 is READ, bank1 is WRITE
  cnt_t   wr_ptr, ld_ptr, ld_base;
  addr_t  rd_addr, rd_cnt;
  logic   rd_vld_q, rd_last_q, err_q;
  logic   busy, ram_re, issue_last;
  logic   start_ok, swap_ok, act_we, ld_we, err_set;
  logic   we0, we1;
  addr_t  waddr0, waddr1;
  data_t  wdata0, wdata1, rdata0, rdata1;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok)   state_nxt = STREAM;
      STREAM:  if (issue_last) state_nxt = DRAIN;
      DRAIN:                   state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // DRAIN is the cycle the last word leaves the RAM, so busy covers it.
  always_comb begin
    busy       = (state != IDLE);
    ram_re     = (state == STREAM);
    issue_last = (state == STREAM) && (rd_cnt == addr_t'(1));
  end

  // ---------------- request decode ----------------
  assign start_ok = (state == IDLE) && bus.rd_start && (bus.rd_len != '0);
  assign swap_ok  = bus.layer_swap && !busy;
  assign act_we   = bus.act_valid && (wr_ptr != FULL_CNT);
  // ld_clr takes effect before a load in the same cycle.
  assign ld_base  = bus.ld_clr ? '0 : ld_ptr;
  assign ld_we    = bus.ld_valid && !busy && (ld_base != FULL_CNT);
  assign err_set  = (bus.act_valid && !act_we) ||
                    (bus.ld_valid && !ld_we) ||
                    (bus.layer_swap && busy);

  // ---------------- pointers, bank select, read pipeline ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel  <= 1'b0;
      wr_ptr    <= '0;
      ld_ptr    <= '0;
      rd_addr   <= '0;
      rd_cnt    <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (start_ok) begin
        rd_addr <= '0;
        rd_cnt  <= bus.rd_len;
      end else if (ram_re) begin
        rd_addr <= rd_addr + addr_t'(1);
        rd_cnt  <= rd_cnt - addr_t'(1);
      end
      // Valid/last follow the issued address by the RAM read latency.
      rd_vld_q  <= ram_re;
      rd_last_q <= issue_last;

      // A same-cycle activation lands in the old write bank; the swap then clears the pointer.
      if (swap_ok) begin
        bank_sel <= ~bank_sel;
        wr_ptr   <= '0;
      end else if (act_we) begin
        wr_ptr <= wr_ptr + cnt_t'(1);
      end

      if (ld_we)           ld_ptr <= ld_base + cnt_t'(1);
      else if (bus.ld_clr) ld_ptr <= '0;

      if (err_set) err_q <= 1'b1;
    end
  end

  // ---------------- bank muxing ----------------
  // Activations go to the WRITE bank, loads to the READ bank; never the same RAM.
  assign we0    = bank_sel ? act_we : ld_we;
  assign waddr0 = bank_sel ? wr_ptr[ADDR_W-1:0] : ld_base[ADDR_W-1:0];
  assign wdata0 = bank_sel ? bus.act_data : bus.ld_data;
  assign we1    = bank_sel ? ld_we : act_we;
  assign waddr1 = bank_sel ? ld_base[ADDR_W-1:0] : wr_ptr[ADDR_W-1:0];
  assign wdata1 = bank_sel ? bus.ld_data : bus.act_data;

  act_bank_ram u_bank0 (
    .clk   (clk),
    .we    (we0),
    .waddr (waddr0),
    .wdata (wdata0),
    .re    (ram_re),
    .raddr (rd_addr),
    .rdata (rdata0)
  );

  act_bank_ram u_bank1 (
    .clk   (clk),
    .we    (we1),
    .waddr (waddr1),
    .wdata (wdata1),
    .re    (ram_re),
    .raddr (rd_addr),
    .rdata (rdata1)
  );

  // bank_sel cannot change while busy, so the read mux is stable for the whole stream.
  assign bus.rd_valid = rd_vld_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.rd_data  = rd_vld_q ? (bank_sel ? rdata1 : rdata0) : '0;
  assign bus.busy     = busy;
  assign bus.wr_count = wr_ptr;
  assign bus.err      = err_q;

endmodule
